// File: rtl/steer_en_gen.sv
// steer_en_gen
// Decides from the left/right load-cell readings whether a rider is on the platform and
// balanced enough to enable steering. Holds the OFF/WAIT/STEER state machine, the settle
// timer and the weight/balance comparators.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pwr_up     system powered; low forces OFF
//   lft_ld     left load-cell reading (unsigned, LD_W bits)
//   rght_ld    right load-cell reading (unsigned, LD_W bits)
//   en_steer   steering enabled (state == STEER)
//   rider_off  no rider present (state == OFF)
//   st         current state: 00 OFF, 01 WAIT, 10 STEER
module steer_en_gen #(
   parameter int unsigned LD_W         = 12,
   parameter int unsigned MIN_RIDER_WT = 'h200,
   parameter int unsigned WT_HYST      = 'h40,
   parameter int unsigned EN_SHIFT     = 2,
   parameter int unsigned DIS_NUM      = 15,
   parameter int unsigned DIS_SHIFT    = 4,
   parameter bit          FAST_SIM     = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pwr_up,
   input  logic [LD_W-1:0] lft_ld,
   input  logic [LD_W-1:0] rght_ld,
   output logic            en_steer,
   output logic            rider_off,
   output logic [1:0]      st
);

   localparam int unsigned SUM_W  = LD_W + 1;
   localparam int unsigned NUM_W  = $clog2(DIS_NUM + 1);
   localparam int unsigned LHS_W  = LD_W + DIS_SHIFT;
   localparam int unsigned RHS_W  = SUM_W + NUM_W;
   // Wide enough for both sides of the disable-ratio compare so neither side truncates.
   localparam int unsigned CMP_W  = (LHS_W > RHS_W) ? LHS_W : RHS_W;
   localparam int unsigned TMR_W  = FAST_SIM ? 15 : 26;
   localparam int unsigned THR_LO = MIN_RIDER_WT - WT_HYST;
   localparam int unsigned THR_HI = MIN_RIDER_WT + WT_HYST;

   typedef enum logic [1:0] {
      StOff   = 2'b00,
      StWait  = 2'b01,
      StSteer = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   cnt_q, cnt_d;
   logic               clr_tmr;
   logic               tmr_full;

   logic [SUM_W-1:0]   sum;
   logic [LD_W:0]      raw_diff;
   logic [LD_W-1:0]    diff;
   logic [CMP_W-1:0]   dis_lhs, dis_rhs;
   logic               sum_lt_min, sum_gt_min, diff_gt_en, diff_gt_dis;

   // Arithmetic: one extra bit on sum and difference so neither wraps.
   always_comb begin
      sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
      raw_diff = {1'b0, lft_ld} - {1'b0, rght_ld};
      // Magnitude of an LD_W+1-bit signed difference always fits in LD_W bits.
      diff     = raw_diff[LD_W] ? LD_W'(-raw_diff) : raw_diff[LD_W-1:0];
      dis_lhs  = CMP_W'(diff) << DIS_SHIFT;
      dis_rhs  = CMP_W'(sum) * CMP_W'(DIS_NUM);
   end

   assign sum_lt_min  = (32'(sum) < THR_LO);
   assign sum_gt_min  = (32'(sum) > THR_HI);
   assign diff_gt_en  = ({1'b0, diff} > (sum >> EN_SHIFT));
   assign diff_gt_dis = (dis_lhs > dis_rhs);

   // Settle timer: saturates so tmr_full holds until the next clear.
   assign tmr_full = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_tmr) begin
         cnt_d = '0;
      end else if (!tmr_full) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   // Next-state logic; branches are ordered by priority.
   always_comb begin
      state_d = state_q;
      clr_tmr = 1'b0;
      if (!pwr_up) begin
         state_d = StOff;
         clr_tmr = 1'b1;
      end else begin
         case (state_q)
            StOff: begin
               if (sum_gt_min) begin
                  state_d = StWait;
                  clr_tmr = 1'b1;
               end
            end
            StWait: begin
               if (sum_lt_min) begin
                  state_d = StOff;
               end else if (diff_gt_en) begin
                  // Imbalance restarts settling even when the timer is already full.
                  clr_tmr = 1'b1;
               end else if (tmr_full) begin
                  state_d = StSteer;
               end
            end
            StSteer: begin
               if (sum_lt_min) begin
                  state_d = StOff;
               end else if (diff_gt_dis) begin
                  state_d = StWait;
                  clr_tmr = 1'b1;
               end
            end
            default: state_d = StOff;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StOff;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore outputs straight from the state flop.
   assign en_steer  = (state_q == StSteer);
   assign rider_off = (state_q == StOff);
   assign st        = state_q;

endmodule
